// File: rtl/dt_blue_hit_if.sv
// Position and status bundle between the game logic and the player contact-damage detector.
interface dt_blue_hit_if;
    logic [9:0] x_blue;
    logic [8:0] y_blue;
    logic [9:0] x_slim;
    logic [8:0] y_slim;
    logic       slim_frozen;
    logic       game_rst;
    logic       hit_pulse;
    logic       invincible;
    logic       blink_on;
    logic [1:0] lives;
    logic       game_over;
    logic       knock_dir;

    modport master (
        output x_blue, y_blue, x_slim, y_slim, slim_frozen, game_rst,
        input  hit_pulse, invincible, blink_on, lives, game_over, knock_dir
    );

    modport slave (
        input  x_blue, y_blue, x_slim, y_slim, slim_frozen, game_rst,
        output hit_pulse, invincible, blink_on, lives, game_over, knock_dir
    );
endinterface

// File: rtl/dt_blue_hit.sv
// Player contact-damage detector: a live slime touching the player costs a life,
// followed by a tick-timed invincibility window with a blinking sprite.
module dt_blue_hit #(
    parameter int BLUE_W    = 47,
    parameter int BLUE_H    = 41,
    parameter int SLIM_W    = 62,
    parameter int SLIM_H    = 36,
    parameter int TICK_DIV  = 6000000,
    parameter int INV_TICKS = 15,
    parameter int LIVES     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    dt_blue_hit_if.slave bus
);

    typedef enum logic [1:0] {
        VULN   = 2'd0,
        HIT    = 2'd1,
        INVULN = 2'd2,
        DEAD   = 2'd3
    } state_t;

    localparam logic [22:0] CYC_LAST  = 23'(TICK_DIV - 1);
    localparam logic [3:0]  TICK_LAST = 4'(INV_TICKS);
    localparam logic [1:0]  LIVES_RST = 2'(LIVES);

    state_t      state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [22:0] cyc_q, cyc_d;
    logic [3:0]  tick_q, tick_d;
    logic        blink_q, blink_d;
    logic        knock_q, knock_d;

    logic [10:0] xb_s, xs_s;
    logic [9:0]  yb_s, ys_s;
    logic        overlap_s, stomp_s, contact_s, knock_s;
    logic        cyc_wrap_s, last_tick_s;

    // Widened operands so that no edge sum can wrap around the screen size.
    assign xb_s = {1'b0, bus.x_blue};
    assign xs_s = {1'b0, bus.x_slim};
    assign yb_s = {1'b0, bus.y_blue};
    assign ys_s = {1'b0, bus.y_slim};

    // Geometric contact classification on the current positions.
    always_comb begin
        overlap_s = (xb_s < xs_s + 11'(SLIM_W)) && (xs_s < xb_s + 11'(BLUE_W)) &&
                    (yb_s < ys_s + 10'(SLIM_H)) && (ys_s < yb_s + 10'(BLUE_H));
        stomp_s   = (yb_s + 10'(BLUE_H + 2) > ys_s) && (yb_s + 10'(BLUE_H) < ys_s + 10'd2);
        contact_s = overlap_s && !stomp_s && !bus.slim_frozen;
        knock_s   = (xb_s + 11'(BLUE_W / 2)) >= (xs_s + 11'(SLIM_W / 2));
    end

    assign cyc_wrap_s  = (cyc_q == CYC_LAST);
    assign last_tick_s = ((tick_q + 4'd1) == TICK_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= VULN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; restart overrides every transition.
    always_comb begin
        state_d = state_q;
        if (bus.game_rst) begin
            state_d = VULN;
        end else begin
            case (state_q)
                VULN: begin
                    if (contact_s) begin
                        state_d = HIT;
                    end else begin
                        state_d = VULN;
                    end
                end
                HIT: begin
                    if (lives_q == 2'd0) begin
                        state_d = DEAD;
                    end else begin
                        state_d = INVULN;
                    end
                end
                INVULN: begin
                    if (cyc_wrap_s && last_tick_s) begin
                        state_d = VULN;
                    end else begin
                        state_d = INVULN;
                    end
                end
                DEAD:    state_d = DEAD;
                default: state_d = VULN;
            endcase
        end
    end

    // Life counter, tick timing, blink phase and knockback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lives_q <= LIVES_RST;
            cyc_q   <= 23'd0;
            tick_q  <= 4'd0;
            blink_q <= 1'b1;
            knock_q <= 1'b0;
        end else begin
            lives_q <= lives_d;
            cyc_q   <= cyc_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
            knock_q <= knock_d;
        end
    end

    // Datapath next values, driven by the current state.
    always_comb begin
        lives_d = lives_q;
        cyc_d   = cyc_q;
        tick_d  = tick_q;
        blink_d = blink_q;
        knock_d = knock_q;
        if (bus.game_rst) begin
            lives_d = LIVES_RST;
            cyc_d   = 23'd0;
            tick_d  = 4'd0;
            blink_d = 1'b1;
            knock_d = 1'b0;
        end else begin
            case (state_q)
                VULN: begin
                    blink_d = 1'b1;
                    if (contact_s) begin
                        lives_d = lives_q - 2'd1;
                        knock_d = knock_s;
                    end else begin
                        knock_d = knock_q;
                    end
                end
                HIT: begin
                    cyc_d   = 23'd0;
                    tick_d  = 4'd0;
                    blink_d = 1'b1;
                end
                INVULN: begin
                    if (cyc_wrap_s) begin
                        cyc_d  = 23'd0;
                        tick_d = tick_q + 4'd1;
                        // The final wrap would leave the sprite dark; show it on exit.
                        if (last_tick_s) begin
                            blink_d = 1'b1;
                        end else begin
                            blink_d = !blink_q;
                        end
                    end else begin
                        cyc_d = cyc_q + 23'd1;
                    end
                end
                DEAD:    blink_d = 1'b1;
                default: blink_d = 1'b1;
            endcase
        end
    end

    // Output decode from registered state only.
    always_comb begin
        bus.hit_pulse  = (state_q == HIT);
        bus.invincible = (state_q == HIT) || (state_q == INVULN);
        bus.game_over  = (state_q == DEAD);
        bus.blink_on   = blink_q;
        bus.lives      = lives_q;
        bus.knock_dir  = knock_q;
    end

endmodule
